multicycle_cla_adder: RTL

- Multi-cycle WIDTH-bit adder/subtractor for the datapath's integer unit.
- Processes one 4-bit group per cycle, LSB group first.
- Each group generates p/g and feeds the team's existing 4-bit lookahead_carry_unit (instantiated once).
- That unit's c_out is registered as the next group's carry-in, so a full add costs WIDTH/4 cycles and needs a single carry unit.
- Valid/ready handshake on input and output; flags for ALU status.

---
 rtl/alu_pkg.sv | 13 +
 rtl/lookahead_carry_unit.sv | 20 ++
 rtl/pg_gen4.sv | 15 +
 rtl/multicycle_cla_adder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle adder family: FSM state encoding
// and the width of one lookahead group.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int GROUP_BITS = 4;

endpackage

// File: rtl/lookahead_carry_unit.sv
// 4-bit carry lookahead unit. c[i] is the carry into bit i of the group
// (c[0] is the group carry-in); c_out is the carry out of bit 3.
module lookahead_carry_unit (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       c_in,
    output logic [3:0] c,
    output logic       c_out
);

    assign c[0]  = c_in;
    assign c[1]  = g[0] | (p[0] & c_in);
    assign c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c_in);

endmodule

// File: rtl/pg_gen4.sv
// Propagate/generate terms for one 4-bit group. Operand B is expected to be
// pre-conditioned (already inverted for subtraction) by the caller.
module pg_gen4
    import alu_pkg::*;
(
    input  logic [GROUP_BITS-1:0] a,
    input  logic [GROUP_BITS-1:0] b,
    output logic [GROUP_BITS-1:0] p,
    output logic [GROUP_BITS-1:0] g
);

    assign p = a ^ b;
    assign g = a & b;

endmodule

// File: rtl/multicycle_cla_adder.sv
// Multi-cycle adder/subtractor: one 4-bit group per cycle, LSB first, with a
// single shared lookahead carry unit whose carry-out is registered as the next
// group's carry-in. Subtraction is A + ~B + 1 using the initial carry-in.
module multicycle_cla_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NGROUPS = WIDTH / GROUP_BITS;
    localparam int IDXW    = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NGROUPS - 1);

    if (((WIDTH % GROUP_BITS) != 0) || (WIDTH < GROUP_BITS)) begin : g_bad_width
        $error("multicycle_cla_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;
    logic              negative_q, negative_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [GROUP_BITS-1:0] grp_a_s;
    logic [GROUP_BITS-1:0] grp_b_s;
    logic [GROUP_BITS-1:0] grp_p_s;
    logic [GROUP_BITS-1:0] grp_g_s;
    logic [GROUP_BITS-1:0] grp_c_s;
    logic                  grp_cout_s;
    logic [GROUP_BITS-1:0] grp_sum_s;
    logic [WIDTH-1:0]      sum_upd_s;

    // Select the operand bits of the group addressed by idx (AND-OR mux).
    always_comb begin
        grp_a_s = {GROUP_BITS{1'b0}};
        grp_b_s = {GROUP_BITS{1'b0}};
        for (int i = 0; i < NGROUPS; i++) begin
            grp_a_s = grp_a_s | ((idx_q == IDXW'(i)) ? a_q[i*GROUP_BITS +: GROUP_BITS]
                                                     : {GROUP_BITS{1'b0}});
            grp_b_s = grp_b_s | ((idx_q == IDXW'(i)) ? b_q[i*GROUP_BITS +: GROUP_BITS]
                                                     : {GROUP_BITS{1'b0}});
        end
    end

    pg_gen4 u_pg_gen4 (
        .a (grp_a_s),
        .b (grp_b_s),
        .p (grp_p_s),
        .g (grp_g_s)
    );

    lookahead_carry_unit u_lcu (
        .p     (grp_p_s),
        .g     (grp_g_s),
        .c_in  (carry_q),
        .c     (grp_c_s),
        .c_out (grp_cout_s)
    );

    assign grp_sum_s = grp_p_s ^ grp_c_s;

    // Result with the current group's sum bits merged in; flags look at this.
    always_comb begin
        sum_upd_s = sum_q;
        for (int i = 0; i < NGROUPS; i++) begin
            sum_upd_s[i*GROUP_BITS +: GROUP_BITS] =
                (idx_q == IDXW'(i)) ? grp_sum_s : sum_q[i*GROUP_BITS +: GROUP_BITS];
        end
    end

    // Next-state, datapath and flag update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        negative_d  = negative_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    idx_d   = {IDXW{1'b0}};
                    sum_d   = {WIDTH{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d   = sum_upd_s;
                carry_d = grp_cout_s;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    carry_out_d = grp_cout_s;
                    // carry into the MSB differs from carry out of it
                    overflow_d  = grp_c_s[GROUP_BITS-1] ^ grp_cout_s;
                    zero_d      = (sum_upd_s == {WIDTH{1'b0}});
                    negative_d  = sum_upd_s[WIDTH-1];
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered decodes of the next state, so
        // in_ready only rises on the edge that completes the output handshake.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous abort to reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            idx_q       <= {IDXW{1'b0}};
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

endmodule
